// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU: branch ops, exception codes and
// the PC exception sequencer states.
package cpu_pkg;

    typedef enum logic [1:0] {
        BR_EQ = 2'b00,
        BR_NE = 2'b01,
        BR_LE = 2'b10,
        BR_GT = 2'b11
    } br_op_e;

    typedef enum logic [1:0] {
        EXC_OPCODE = 2'b00,
        EXC_OVF    = 2'b01,
        EXC_DIV0   = 2'b10
    } exc_code_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_WAIT  = 2'b10,
        S_LOAD  = 2'b11
    } seq_state_e;

    // The reserved code shares the invalid-opcode vector.
    function automatic logic [1:0] norm_exc_code(input logic [1:0] code);
        return (code == 2'b11) ? EXC_OPCODE : code;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from ALU flags; purely combinational.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [1:0] branch_op,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_gt,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (br_op_e'(branch_op))
            BR_EQ: taken = alu_zero;
            BR_NE: taken = ~alu_zero;
            BR_LE: taken = alu_zero | alu_lt;
            BR_GT: taken = alu_gt;
        endcase
    end

endmodule

// File: rtl/pc_update_unit.sv
// PC register with branch-qualified loads, EPC capture and a vector-fetch
// exception sequencer. Optional return-from-exception path: PC_UPDATE_RTE_EN.
module pc_update_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] VEC_BASE   = 32'd253,
    parameter logic [31:0] EPC_OFFSET = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next_in,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic [1:0]  branch_op,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        alu_gt,
    input  logic        exc_req,
    input  logic [1:0]  exc_code,
`ifdef PC_UPDATE_RTE_EN
    input  logic        rte,
`endif
    input  logic [7:0]  vec_data_in,
    output logic [31:0] pc_out,
    output logic [31:0] epc_out,
    output logic [31:0] vec_addr_out,
    output logic        vec_rd,
    output logic        exc_busy,
    output logic        pc_loaded
);

    seq_state_e  r_state;
    seq_state_e  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic [1:0]  r_code;
    logic        r_loaded;
    logic        r_busy;

    logic w_cond;
    logic w_load;
    logic w_idle;
    logic w_exc_take;
    logic w_rte_take;
    logic w_vec_rd;

    branch_cond u_branch_cond (
        .branch_op (branch_op),
        .alu_zero  (alu_zero),
        .alu_lt    (alu_lt),
        .alu_gt    (alu_gt),
        .taken     (w_cond)
    );

    assign w_load     = PCWrite | (PCWriteCond & w_cond);
    assign w_idle     = (r_state == S_IDLE);
    assign w_exc_take = w_idle & exc_req;
`ifdef PC_UPDATE_RTE_EN
    assign w_rte_take = w_idle & rte & ~exc_req;
`else
    assign w_rte_take = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (exc_req) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_IDLE;
        endcase
    end

    // Exception capture outranks return, which outranks a normal load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_epc    <= '0;
            r_code   <= EXC_OPCODE;
            r_loaded <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_loaded <= 1'b0;
            r_busy   <= (w_state_nxt != S_IDLE);
            if (w_exc_take) begin
                r_epc  <= r_pc - EPC_OFFSET;
                r_code <= norm_exc_code(exc_code);
            end else if (w_rte_take) begin
                r_pc     <= r_epc;
                r_loaded <= 1'b1;
            end else if (w_idle && w_load) begin
                r_pc     <= pc_next_in;
                r_loaded <= 1'b1;
            end else if (r_state == S_LOAD) begin
                r_pc     <= {24'b0, vec_data_in};
                r_loaded <= 1'b1;
            end
        end
    end

    assign w_vec_rd     = (r_state == S_FETCH) || (r_state == S_WAIT);
    assign vec_rd       = w_vec_rd;
    assign vec_addr_out = w_vec_rd ? (VEC_BASE + {30'b0, r_code}) : 32'd0;
    assign pc_out       = r_pc;
    assign epc_out      = r_epc;
    assign exc_busy     = r_busy;
    assign pc_loaded    = r_loaded;

endmodule

// File: tb/tb_pc_update_unit.sv
// Bench for pc_update_unit: directed test-plan cases with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pc_update_unit;

    localparam logic [31:0] RESET_PC   = 32'd0;
    localparam logic [31:0] VEC_BASE   = 32'd253;
    localparam logic [31:0] EPC_OFFSET = 32'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_next_in;
    logic        PCWrite, PCWriteCond;
    logic [1:0]  branch_op;
    logic        alu_zero, alu_lt, alu_gt;
    logic        exc_req;
    logic [1:0]  exc_code;
    logic        rte;
    logic [7:0]  vec_data_in;
    logic [31:0] pc_out, epc_out, vec_addr_out;
    logic        vec_rd, exc_busy, pc_loaded;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: phase 0 idle, 1..3 = cycles into the vector sequence.
    logic [31:0] m_pc, m_epc;
    int          m_phase, m_code;
    logic        m_loaded;

    always #5 clk = ~clk;

    pc_update_unit #(.RESET_PC(RESET_PC), .VEC_BASE(VEC_BASE), .EPC_OFFSET(EPC_OFFSET)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_next_in   (pc_next_in),
        .PCWrite      (PCWrite),
        .PCWriteCond  (PCWriteCond),
        .branch_op    (branch_op),
        .alu_zero     (alu_zero),
        .alu_lt       (alu_lt),
        .alu_gt       (alu_gt),
        .exc_req      (exc_req),
        .exc_code     (exc_code),
`ifdef PC_UPDATE_RTE_EN
        .rte          (rte),
`endif
        .vec_data_in  (vec_data_in),
        .pc_out       (pc_out),
        .epc_out      (epc_out),
        .vec_addr_out (vec_addr_out),
        .vec_rd       (vec_rd),
        .exc_busy     (exc_busy),
        .pc_loaded    (pc_loaded)
    );

    function automatic logic cond_met(input logic [1:0] op, input logic z, lt, gt);
        case (op)
            2'd0:    return z;
            2'd1:    return !z;
            2'd2:    return z || lt;
            default: return gt;
        endcase
    endfunction

    function automatic logic rte_active();
`ifdef PC_UPDATE_RTE_EN
        return rte;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_pc = RESET_PC; m_epc = 32'd0; m_phase = 0; m_loaded = 1'b0;
        end else begin
            m_loaded = 1'b0;
            case (m_phase)
                0: begin
                    if (exc_req) begin
                        m_epc   = m_pc - EPC_OFFSET;
                        m_code  = (exc_code == 2'd3) ? 0 : int'(exc_code);
                        m_phase = 1;
                    end else if (rte_active()) begin
                        m_pc = m_epc; m_loaded = 1'b1;
                    end else if (PCWrite || (PCWriteCond && cond_met(branch_op, alu_zero, alu_lt, alu_gt))) begin
                        m_pc = pc_next_in; m_loaded = 1'b1;
                    end
                end
                1: m_phase = 2;
                2: m_phase = 3;
                default: begin
                    m_pc = {24'd0, vec_data_in}; m_loaded = 1'b1; m_phase = 0;
                end
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        logic rd_exp;
        rd_exp = (m_phase == 1) || (m_phase == 2);
        chk("pc_out", pc_out, m_pc);
        chk("epc_out", epc_out, m_epc);
        chk("vec_rd", {31'd0, vec_rd}, {31'd0, rd_exp});
        chk("vec_addr_out", vec_addr_out, rd_exp ? VEC_BASE + 32'(m_code) : 32'd0);
        chk("exc_busy", {31'd0, exc_busy}, {31'd0, m_phase != 0});
        chk("pc_loaded", {31'd0, pc_loaded}, {31'd0, m_loaded});
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_compare();
    endtask

    task automatic idle_inputs();
        reset = 1'b0; pc_next_in = 32'd0; PCWrite = 1'b0; PCWriteCond = 1'b0;
        branch_op = 2'd0; alu_zero = 1'b0; alu_lt = 1'b0; alu_gt = 1'b0;
        exc_req = 1'b0; exc_code = 2'd0; rte = 1'b0;
    endtask

    task automatic branch(input logic [1:0] op, input logic z, lt, gt, input logic [31:0] nxt);
        idle_inputs();
        PCWriteCond = 1'b1; branch_op = op; alu_zero = z; alu_lt = lt; alu_gt = gt; pc_next_in = nxt;
        step();
    endtask

    initial begin
        m_pc = 32'd0; m_epc = 32'd0; m_phase = 0; m_code = 0; m_loaded = 1'b0;
        idle_inputs();
        vec_data_in = 8'h00;
        reset = 1'b1;
        step(); step();
        chk("reset pc", pc_out, 32'd0);
        chk("reset epc", epc_out, 32'd0);
        chk("reset busy", {31'd0, exc_busy}, 32'd0);

        idle_inputs(); PCWrite = 1'b1; pc_next_in = 32'h40;
        step();
        chk("pcwrite pc", pc_out, 32'h40);
        chk("pcwrite pulse", {31'd0, pc_loaded}, 32'd1);
        idle_inputs(); step();
        chk("pulse single", {31'd0, pc_loaded}, 32'd0);

        branch(2'd0, 1'b0, 1'b0, 1'b0, 32'h80);
        chk("beq not taken", pc_out, 32'h40);
        branch(2'd0, 1'b1, 1'b0, 1'b0, 32'h80);
        chk("beq taken", pc_out, 32'h80);
        branch(2'd1, 1'b1, 1'b0, 1'b0, 32'h84);
        chk("bne not taken", pc_out, 32'h80);
        branch(2'd1, 1'b0, 1'b0, 1'b0, 32'h90);
        chk("bne taken", pc_out, 32'h90);
        branch(2'd2, 1'b0, 1'b1, 1'b0, 32'hA0);
        chk("ble taken", pc_out, 32'hA0);
        branch(2'd3, 1'b0, 1'b1, 1'b0, 32'hB0);
        chk("bgt not taken", pc_out, 32'hA0);
        branch(2'd3, 1'b0, 1'b0, 1'b1, 32'h100);
        chk("bgt taken", pc_out, 32'h100);

        // Exception with a colliding PCWrite; second request during WAIT.
        idle_inputs(); exc_req = 1'b1; exc_code = 2'd1; PCWrite = 1'b1; pc_next_in = 32'h200;
        vec_data_in = 8'h5A;
        step();
        chk("epc capture", epc_out, 32'hFC);
        chk("fetch addr", vec_addr_out, 32'd254);
        chk("fetch rd", {31'd0, vec_rd}, 32'd1);
        chk("pcwrite ignored", pc_out, 32'h100);
        idle_inputs(); step();
        chk("wait rd", {31'd0, vec_rd}, 32'd1);
        exc_req = 1'b1; exc_code = 2'd2; PCWrite = 1'b1; pc_next_in = 32'h300;
        step();
        chk("load busy", {31'd0, exc_busy}, 32'd1);
        chk("load rd off", {31'd0, vec_rd}, 32'd0);
        idle_inputs(); step();
        chk("vector pc", pc_out, 32'h5A);
        chk("vector pulse", {31'd0, pc_loaded}, 32'd1);
        chk("epc kept", epc_out, 32'hFC);

`ifdef PC_UPDATE_RTE_EN
        idle_inputs(); rte = 1'b1; step();
        chk("rte pc", pc_out, 32'hFC);
        idle_inputs(); rte = 1'b1; exc_req = 1'b1; step();
        chk("exc over rte", {31'd0, exc_busy}, 32'd1);
        idle_inputs(); step(); step(); step();
`endif

        // Reset lands while the sequencer is in WAIT.
        idle_inputs(); exc_req = 1'b1; exc_code = 2'd3; step();
        chk("reserved addr", vec_addr_out, 32'd253);
        idle_inputs(); step();
        reset = 1'b1; step();
        chk("abort pc", pc_out, RESET_PC);
        chk("abort epc", epc_out, 32'd0);
        chk("abort rd", {31'd0, vec_rd}, 32'd0);
        chk("abort busy", {31'd0, exc_busy}, 32'd0);
        idle_inputs(); step(); step();

        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            pc_next_in  = $urandom;
            PCWrite     = ($urandom_range(0, 3) == 0);
            PCWriteCond = ($urandom_range(0, 2) == 0);
            branch_op   = 2'($urandom_range(0, 3));
            alu_zero    = 1'($urandom);
            alu_lt      = 1'($urandom);
            alu_gt      = 1'($urandom);
            exc_req     = ($urandom_range(0, 7) == 0);
            exc_code    = 2'($urandom_range(0, 3));
            rte         = ($urandom_range(0, 9) == 0);
            if (m_phase == 0) vec_data_in = 8'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
